id_ex_operand_reg: RTL and testbench

ID/EX pipeline register for the 16-bit SIMPLE pipeline, placed directly downstream of the forwarding unit. It consumes the 2-bit forwarding selects for both source operands and muxes register-file data, the EX-stage result or the MEM-stage result into the ID/EX register. It detects load-use hazards, stalling ID and inserting a bubble. It handles downstream hold and branch flush, and its `ex_rd`/`ex_regwrite` outputs feed back into the forwarding unit as the ID/EX-stage producer.

---
 rtl/id_ex_operand_reg_pkg.sv | 23 ++
 rtl/id_ex_operand_reg_if.sv | 51 +++++
 rtl/id_ex_operand_reg_mux.sv | 26 ++
 rtl/id_ex_operand_reg.sv | 91 +++++++++
 tb/tb_id_ex_operand_reg.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/id_ex_operand_reg_pkg.sv
// Shared definitions for the 16-bit SIMPLE pipeline: widths, forwarding-select
// encodings and the ID/EX control bundle.
package simple_pkg;

  localparam int DATA_W      = 16;  // operand/result width
  localparam int REG_W       = 3;   // register address width (8 registers)
  localparam int CTRL_W      = 8;   // opaque control bundle passed to EX
  localparam int STALL_CNT_W = 16;  // load-use stall counter width

  // Forwarding select bits; both set means both producers match and EX wins.
  localparam logic [1:0] FWD_EX  = 2'b10;
  localparam logic [1:0] FWD_MEM = 2'b01;

  typedef struct packed {
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rd;
    logic [CTRL_W-1:0] ctrl;
    logic              regwrite;
    logic              memread;
    logic              valid;
  } id_ex_bundle_t;

endpackage

// File: rtl/id_ex_operand_reg_if.sv
// ID -> ID/EX -> EX signal bundle.
//   slave  : the ID/EX register (consumes ID/forwarding inputs, drives ex_*)
//   master : the surrounding pipeline (drives ID/forwarding inputs)
interface id_ex_operand_reg_if;
  import simple_pkg::*;

  logic                   id_valid;
  logic [REG_W-1:0]       id_rs;
  logic [REG_W-1:0]       id_rd;
  logic                   id_use_a;
  logic                   id_use_b;
  logic [DATA_W-1:0]      id_rs_data;
  logic [DATA_W-1:0]      id_rd_data;
  logic [CTRL_W-1:0]      id_ctrl;
  logic                   id_regwrite;
  logic                   id_memread;
  logic [1:0]             fwd_a;
  logic [1:0]             fwd_b;
  logic [DATA_W-1:0]      ex_result;
  logic [DATA_W-1:0]      mem_result;
  logic                   ex_stall;
  logic                   flush;

  logic                   id_stall;
  logic                   ex_valid;
  logic                   ex_regwrite;
  logic                   ex_memread;
  logic [DATA_W-1:0]      ex_a;
  logic [DATA_W-1:0]      ex_b;
  logic [REG_W-1:0]       ex_rs;
  logic [REG_W-1:0]       ex_rd;
  logic [CTRL_W-1:0]      ex_ctrl;
  logic [STALL_CNT_W-1:0] stall_count;

  modport slave (
    input  id_valid, id_rs, id_rd, id_use_a, id_use_b, id_rs_data, id_rd_data,
           id_ctrl, id_regwrite, id_memread, fwd_a, fwd_b, ex_result,
           mem_result, ex_stall, flush,
    output id_stall, ex_valid, ex_regwrite, ex_memread, ex_a, ex_b, ex_rs,
           ex_rd, ex_ctrl, stall_count
  );

  modport master (
    output id_valid, id_rs, id_rd, id_use_a, id_use_b, id_rs_data, id_rd_data,
           id_ctrl, id_regwrite, id_memread, fwd_a, fwd_b, ex_result,
           mem_result, ex_stall, flush,
    input  id_stall, ex_valid, ex_regwrite, ex_memread, ex_a, ex_b, ex_rs,
           ex_rd, ex_ctrl, stall_count
  );

endinterface

// File: rtl/id_ex_operand_reg_mux.sv
// operand_fwd_mux: combinational 3-input priority mux for one source operand.
//   sel       : forwarding select (bit1 = EX producer, bit0 = MEM producer)
//   rfData    : register-file read data
//   exResult  : ALU output of the instruction in ID/EX
//   memResult : result held in EX/MEM
//   operand   : resolved operand
module operand_fwd_mux
  import simple_pkg::*;
(
  input  logic [1:0]        sel,
  input  logic [DATA_W-1:0] rfData,
  input  logic [DATA_W-1:0] exResult,
  input  logic [DATA_W-1:0] memResult,
  output logic [DATA_W-1:0] operand
);

  always_comb begin
    operand = rfData;
    // EX checked first: it is the most recent producer.
    if ((sel & FWD_EX) != '0)
      operand = exResult;
    else if ((sel & FWD_MEM) != '0)
      operand = memResult;
  end

endmodule

// File: rtl/id_ex_operand_reg.sv
// id_ex_operand_reg: ID/EX pipeline register with operand forwarding muxes,
// load-use hazard detection (one bubble per hazard), downstream hold and
// branch flush (deferred if it arrives during a hold).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : ID-side inputs, forwarding selects/results, ex_stall/flush;
//                drives id_stall, ex_* fields and stall_count
module id_ex_operand_reg
  import simple_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  id_ex_operand_reg_if.slave bus
);

  id_ex_bundle_t          exQ;
  logic [DATA_W-1:0]      exAQ;
  logic [DATA_W-1:0]      exBQ;
  logic [STALL_CNT_W-1:0] stallCntQ;
  logic                   flushPend;

  logic [DATA_W-1:0]      aMux;
  logic [DATA_W-1:0]      bMux;
  logic                   loadUse;

  operand_fwd_mux muxA (
    .sel       (bus.fwd_a),
    .rfData    (bus.id_rs_data),
    .exResult  (bus.ex_result),
    .memResult (bus.mem_result),
    .operand   (aMux)
  );

  operand_fwd_mux muxB (
    .sel       (bus.fwd_b),
    .rfData    (bus.id_rd_data),
    .exResult  (bus.ex_result),
    .memResult (bus.mem_result),
    .operand   (bMux)
  );

  // A load in ID/EX has no data yet; any consumer matching it must wait one cycle.
  assign loadUse = exQ.valid & exQ.memread &
                   ((bus.id_use_a & bus.fwd_a[1]) | (bus.id_use_b & bus.fwd_b[1]));

  assign bus.id_stall = bus.ex_stall | loadUse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exQ       <= '0;
      exAQ      <= '0;
      exBQ      <= '0;
      stallCntQ <= '0;
      flushPend <= 1'b0;
    end else if (bus.ex_stall) begin
      // Hold everything; remember a flush so it is not lost.
      if (bus.flush)
        flushPend <= 1'b1;
    end else if (bus.flush || flushPend) begin
      exQ       <= '0;
      exAQ      <= '0;
      exBQ      <= '0;
      flushPend <= 1'b0;
    end else if (loadUse) begin
      exQ  <= '0;
      exAQ <= '0;
      exBQ <= '0;
      if (stallCntQ != '1)
        stallCntQ <= stallCntQ + 1'b1;
    end else begin
      exQ.valid    <= bus.id_valid;
      exQ.regwrite <= bus.id_valid & bus.id_regwrite;
      exQ.memread  <= bus.id_valid & bus.id_memread;
      exQ.rs       <= bus.id_rs;
      exQ.rd       <= bus.id_rd;
      exQ.ctrl     <= bus.id_ctrl;
      exAQ         <= aMux;
      exBQ         <= bMux;
    end
  end

  assign bus.ex_valid    = exQ.valid;
  assign bus.ex_regwrite = exQ.regwrite;
  assign bus.ex_memread  = exQ.memread;
  assign bus.ex_rs       = exQ.rs;
  assign bus.ex_rd       = exQ.rd;
  assign bus.ex_ctrl     = exQ.ctrl;
  assign bus.ex_a        = exAQ;
  assign bus.ex_b        = exBQ;
  assign bus.stall_count = stallCntQ;

endmodule

// File: tb/tb_id_ex_operand_reg.sv
module tb_id_ex_operand_reg;

  logic clk;
  logic rst_n;

  int unsigned nVec;
  int unsigned nErr;

  id_ex_operand_reg_if bus ();

  id_ex_operand_reg dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.id_valid = 0; bus.id_rs = 0; bus.id_rd = 0;
    bus.id_use_a = 0; bus.id_use_b = 0;
    bus.id_rs_data = 0; bus.id_rd_data = 0; bus.id_ctrl = 0;
    bus.id_regwrite = 0; bus.id_memread = 0;
    bus.fwd_a = 0; bus.fwd_b = 0;
    bus.ex_result = 0; bus.mem_result = 0;
    bus.ex_stall = 0; bus.flush = 0;
  endtask

  task automatic chkZero(input string tag);
    chk({tag, "_valid"}, 32'(bus.ex_valid), 0);
    chk({tag, "_regwrite"}, 32'(bus.ex_regwrite), 0);
    chk({tag, "_memread"}, 32'(bus.ex_memread), 0);
    chk({tag, "_a"}, 32'(bus.ex_a), 0);
    chk({tag, "_b"}, 32'(bus.ex_b), 0);
    chk({tag, "_rs"}, 32'(bus.ex_rs), 0);
    chk({tag, "_rd"}, 32'(bus.ex_rd), 0);
    chk({tag, "_ctrl"}, 32'(bus.ex_ctrl), 0);
    chk({tag, "_cnt"}, 32'(bus.stall_count), 0);
    chk({tag, "_idstall"}, 32'(bus.id_stall), 0);
  endtask

  initial begin
    nVec = 0;
    nErr = 0;
    idle();
    rst_n = 1'b0;
    #1;
    chkZero("rst0");
    tick();
    tick();
    rst_n = 1'b1;

    // Forward A from EX
    bus.id_valid = 1; bus.id_rs = 3'd1; bus.id_rd = 3'd2; bus.id_use_a = 1;
    bus.id_rs_data = 16'hAAAA; bus.id_rd_data = 16'h5555; bus.id_ctrl = 8'h3C;
    bus.id_regwrite = 1; bus.fwd_a = 2'b10; bus.ex_result = 16'h1234;
    #1;
    chk("fwdA_idstall", 32'(bus.id_stall), 0);
    tick();
    chk("fwdA_a", 32'(bus.ex_a), 32'h1234);
    chk("fwdA_b_rf", 32'(bus.ex_b), 32'h5555);
    chk("fwdA_valid", 32'(bus.ex_valid), 1);
    chk("fwdA_regwrite", 32'(bus.ex_regwrite), 1);
    chk("fwdA_memread", 32'(bus.ex_memread), 0);
    chk("fwdA_rs", 32'(bus.ex_rs), 1);
    chk("fwdA_rd", 32'(bus.ex_rd), 2);
    chk("fwdA_ctrl", 32'(bus.ex_ctrl), 32'h3C);

    // Both selects set on B: EX wins; A from MEM. This instruction is a load.
    bus.fwd_a = 2'b01; bus.fwd_b = 2'b11;
    bus.ex_result = 16'h1111; bus.mem_result = 16'h2222; bus.id_memread = 1;
    tick();
    chk("fwd11_b", 32'(bus.ex_b), 32'h1111);
    chk("fwdMem_a", 32'(bus.ex_a), 32'h2222);
    chk("load_memread", 32'(bus.ex_memread), 1);

    // Load-use on B
    bus.id_memread = 0; bus.fwd_a = 2'b00; bus.id_use_a = 0;
    bus.fwd_b = 2'b10; bus.id_use_b = 1; bus.ex_result = 16'h9999;
    #1;
    chk("lu_idstall", 32'(bus.id_stall), 1);
    tick();
    chk("lu_valid", 32'(bus.ex_valid), 0);
    chk("lu_cnt", 32'(bus.stall_count), 1);
    chk("lu_b_zero", 32'(bus.ex_b), 0);
    bus.fwd_b = 2'b01; bus.mem_result = 16'hBEEF;
    #1;
    chk("lu2_idstall", 32'(bus.id_stall), 0);
    tick();
    chk("lu2_b", 32'(bus.ex_b), 32'hBEEF);
    chk("lu2_valid", 32'(bus.ex_valid), 1);

    // Hazard conditions but operand B unused: no stall
    bus.fwd_b = 2'b00; bus.id_use_b = 0; bus.id_memread = 1;
    tick();
    bus.id_memread = 0; bus.fwd_b = 2'b10; bus.ex_result = 16'h7777;
    bus.id_rd_data = 16'h0042;
    #1;
    chk("nouse_idstall", 32'(bus.id_stall), 0);
    tick();
    chk("nouse_valid", 32'(bus.ex_valid), 1);
    chk("nouse_b", 32'(bus.ex_b), 32'h7777);
    chk("nouse_cnt", 32'(bus.stall_count), 1);

    // Invalid ID instruction gates regwrite/memread
    bus.fwd_b = 2'b00; bus.id_valid = 0; bus.id_regwrite = 1; bus.id_memread = 1;
    tick();
    chk("inv_valid", 32'(bus.ex_valid), 0);
    chk("inv_regwrite", 32'(bus.ex_regwrite), 0);
    chk("inv_memread", 32'(bus.ex_memread), 0);

    // Deferred flush
    bus.id_valid = 1; bus.id_memread = 0; bus.id_rs_data = 16'h0101;
    tick();
    chk("pre_a", 32'(bus.ex_a), 32'h0101);
    bus.ex_stall = 1; bus.flush = 1; bus.id_rs_data = 16'h0202;
    #1;
    chk("hold_idstall", 32'(bus.id_stall), 1);
    tick();
    chk("hold1_a", 32'(bus.ex_a), 32'h0101);
    chk("hold1_valid", 32'(bus.ex_valid), 1);
    tick();
    chk("hold2_a", 32'(bus.ex_a), 32'h0101);
    chk("hold2_valid", 32'(bus.ex_valid), 1);
    bus.ex_stall = 0; bus.flush = 0;
    tick();
    chk("pflush_valid", 32'(bus.ex_valid), 0);
    chk("pflush_a", 32'(bus.ex_a), 0);
    tick();
    chk("postflush_a", 32'(bus.ex_a), 32'h0202);
    chk("postflush_valid", 32'(bus.ex_valid), 1);

    // Flush and load-use together: bubble, counter unchanged
    bus.id_memread = 1;
    tick();
    bus.id_memread = 0; bus.flush = 1; bus.fwd_b = 2'b10; bus.id_use_b = 1;
    #1;
    chk("flu_idstall", 32'(bus.id_stall), 1);
    tick();
    chk("flu_valid", 32'(bus.ex_valid), 0);
    chk("flu_cnt", 32'(bus.stall_count), 1);
    bus.flush = 0;

    // Four more load-use bubbles bring the counter to 5
    for (int i = 0; i < 4; i++) begin
      bus.fwd_b = 2'b00; bus.id_use_b = 0; bus.id_memread = 1;
      tick();
      bus.fwd_b = 2'b10; bus.id_use_b = 1; bus.id_memread = 0;
      tick();
      chk("lu_loop_cnt", 32'(bus.stall_count), 32'(i + 2));
    end
    bus.fwd_b = 2'b00; bus.id_use_b = 0;
    tick();
    chk("prerst_valid", 32'(bus.ex_valid), 1);
    chk("prerst_cnt", 32'(bus.stall_count), 5);

    // Asynchronous reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    chkZero("rstmid");
    #1;
    rst_n = 1'b1;

    // Reset discards a pending flush
    tick();
    bus.ex_stall = 1; bus.flush = 1;
    tick();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    bus.ex_stall = 0; bus.flush = 0; bus.id_rs_data = 16'h0303;
    tick();
    chk("rstpend_valid", 32'(bus.ex_valid), 1);
    chk("rstpend_a", 32'(bus.ex_a), 32'h0303);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
